// File: rtl/fft_pkg.sv
// Shared FFT datapath types and constants.
// Used by the sample loader and the butterfly unit.
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;
    localparam int DATA_W    = 24;
    localparam int GUARD     = 6;

    localparam logic [DATA_W-1:0] TW_ONE = 24'h7fffff;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef enum logic {
        ST_FILL,
        ST_HOLD
    } ld_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(
        input logic [FFT_LOG2N-1:0] a
    );
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = a[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Ping-pong frame buffer: 2N complex words, one write and one read port.
// Address MSB selects the bank; read data is registered.
module fft_bank_ram
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [FFT_LOG2N:0]   wr_addr,
    input  complex_t             wr_data,
    input  logic [FFT_LOG2N:0]   rd_addr,
    output complex_t             rd_data
);

    complex_t mem [2*FFT_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// FFT input stage: scales audio samples and stores each frame
// bit-reversed into a ping-pong buffer for the FFT engine.
module fft_sample_loader
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  overrun,
    output logic                  frame_valid,
    input  logic                  frame_done,
    input  logic [FFT_LOG2N-1:0]  rd_addr,
    output logic [2*DATA_W-1:0]   rd_data
);

    ld_state_t             state, state_nxt;
    logic [FFT_LOG2N-1:0]  wr_cnt, wr_cnt_nxt;
    logic                  bank, bank_nxt;
    logic                  fv_nxt;
    logic                  accept;
    logic                  last;
    logic                  rd_free;
    logic signed [DATA_W-1:0] scaled;
    complex_t              wr_word;
    complex_t              rd_word;

    assign sample_ready = (state == ST_FILL);
    assign accept       = sample_valid && sample_ready;
    assign last         = (wr_cnt == FFT_LOG2N'(FFT_N - 1));
    assign rd_free      = !frame_valid || frame_done;

    assign scaled  = $signed(sample_in) >>> GUARD;
    assign wr_word = '{re: scaled, im: '0};

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        bank_nxt   = bank;
        fv_nxt     = frame_valid;
        // Released read bank empties unless a new frame swaps in below
        if (frame_done) begin
            fv_nxt = 1'b0;
        end
        unique case (state)
            ST_FILL: begin
                if (accept) begin
                    if (!last) begin
                        wr_cnt_nxt = wr_cnt + 1'b1;
                    end else if (rd_free) begin
                        bank_nxt   = ~bank;
                        wr_cnt_nxt = '0;
                        fv_nxt     = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_done) begin
                    bank_nxt   = ~bank;
                    wr_cnt_nxt = '0;
                    fv_nxt     = 1'b1;
                    state_nxt  = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FILL;
            wr_cnt      <= '0;
            bank        <= 1'b0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_cnt      <= wr_cnt_nxt;
            bank        <= bank_nxt;
            frame_valid <= fv_nxt;
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end
    end

    fft_bank_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr ({bank, bitrev(wr_cnt)}),
        .wr_data (wr_word),
        .rd_addr ({~bank, rd_addr}),
        .rd_data (rd_word)
    );

    assign rd_data = rd_word;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed self-checking bench for fft_sample_loader.
module tb_fft_sample_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        frame_valid;
    logic        frame_done;
    logic [3:0]  rd_addr;
    logic [47:0] rd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_sample_loader dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_valid  (frame_valid),
        .frame_done   (frame_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    function automatic logic [3:0] rev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic apply_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        frame_done   = 1'b0;
        sample_in    = '0;
        rd_addr      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [23:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] a, output logic [47:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        frame_done   = 1'b0;
        sample_in    = '0;
        rd_addr      = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sample_ready, overrun, frame_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 100",
                     {sample_ready, overrun, frame_valid});
        end
        vectors++;
        if (rd_data !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_bitrev_frame();
        logic [47:0] d;
        logic        early;
        apply_reset();
        early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (frame_valid) early = 1'b1;
            sample_in    = 24'(k * 64);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL fv_early: got 1 expected 0");
        end
        vectors++;
        if (frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fv_rise: got %b expected 1", frame_valid);
        end
        for (int a = 0; a < 16; a++) begin
            read_at(4'(a), d);
            vectors++;
            if (d !== {24'(rev4(4'(a))), 24'h0}) begin
                miscompares++;
                $display("FAIL bitrev_rd[%0d]: got %h expected %h",
                         a, d, {24'(rev4(4'(a))), 24'h0});
            end
        end
    endtask

    task automatic test_scaling();
        logic [47:0] d;
        apply_reset();
        push(24'h7fffff);
        push(24'h800000);
        push(24'hffffc0);
        for (int k = 3; k < 16; k++) push(24'h0);
        read_at(4'd0, d);
        vectors++;
        if (d !== {24'h01ffff, 24'h0}) begin
            miscompares++;
            $display("FAIL scale_max: got %h expected 01ffff000000", d);
        end
        read_at(4'd8, d);
        vectors++;
        if (d !== {24'hfe0000, 24'h0}) begin
            miscompares++;
            $display("FAIL scale_min: got %h expected fe0000000000", d);
        end
        read_at(4'd4, d);
        vectors++;
        if (d !== {24'hffffff, 24'h0}) begin
            miscompares++;
            $display("FAIL scale_neg1: got %h expected ffffff000000", d);
        end
    endtask

    task automatic test_overrun_hold();
        logic [47:0] d;
        apply_reset();
        for (int k = 0; k < 16; k++) push(24'(k * 64));
        for (int k = 0; k < 16; k++) push(24'((200 + k) * 64));
        vectors++;
        if ({sample_ready, overrun, frame_valid} !== 3'b001) begin
            miscompares++;
            $display("FAIL hold_flags: got %b expected 001",
                     {sample_ready, overrun, frame_valid});
        end
        push(24'h00abc0);
        vectors++;
        if ({sample_ready, overrun} !== 2'b01) begin
            miscompares++;
            $display("FAIL overrun_set: got %b expected 01",
                     {sample_ready, overrun});
        end
        read_at(4'd1, d);
        vectors++;
        if (d !== {24'd8, 24'h0}) begin
            miscompares++;
            $display("FAIL hold_read: got %h expected %h", d, {24'd8, 24'h0});
        end
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        vectors++;
        if ({sample_ready, overrun, frame_valid} !== 3'b111) begin
            miscompares++;
            $display("FAIL release_flags: got %b expected 111",
                     {sample_ready, overrun, frame_valid});
        end
        read_at(4'd1, d);
        vectors++;
        if (d !== {24'd208, 24'h0}) begin
            miscompares++;
            $display("FAIL frame2_rd1: got %h expected %h", d, {24'd208, 24'h0});
        end
        read_at(4'd0, d);
        vectors++;
        if (d !== {24'd200, 24'h0}) begin
            miscompares++;
            $display("FAIL frame2_rd0: got %h expected %h", d, {24'd200, 24'h0});
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] d;
        logic        dropped;
        apply_reset();
        for (int k = 0; k < 16; k++) push(24'((300 + k) * 64));
        dropped = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!sample_ready) dropped = 1'b1;
            sample_in    = 24'((400 + k) * 64);
            sample_valid = 1'b1;
            frame_done   = (k == 15);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        frame_done   = 1'b0;
        if (!sample_ready) dropped = 1'b1;
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_drop: got 1 expected 0");
        end
        vectors++;
        if (frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_fv: got %b expected 1", frame_valid);
        end
        read_at(4'd0, d);
        vectors++;
        if (d !== {24'd400, 24'h0}) begin
            miscompares++;
            $display("FAIL b2b_rd0: got %h expected %h", d, {24'd400, 24'h0});
        end
        read_at(4'd15, d);
        vectors++;
        if (d !== {24'd415, 24'h0}) begin
            miscompares++;
            $display("FAIL b2b_rd15: got %h expected %h", d, {24'd415, 24'h0});
        end
    endtask

    task automatic test_reset_midfill();
        logic [47:0] d;
        apply_reset();
        for (int k = 0; k < 7; k++) push(24'((50 + k) * 64));
        apply_reset();
        vectors++;
        if ({sample_ready, frame_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL midfill_reset: got %b expected 10",
                     {sample_ready, frame_valid});
        end
        for (int k = 0; k < 16; k++) push(24'((100 + k) * 64));
        vectors++;
        if (frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midfill_fv: got %b expected 1", frame_valid);
        end
        for (int a = 0; a < 16; a++) begin
            read_at(4'(a), d);
            vectors++;
            if (d !== {24'(100 + rev4(4'(a))), 24'h0}) begin
                miscompares++;
                $display("FAIL midfill_rd[%0d]: got %h expected %h",
                         a, d, {24'(100 + rev4(4'(a))), 24'h0});
            end
        end
    endtask

    task automatic test_spurious_done();
        logic [47:0] d;
        apply_reset();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        vectors++;
        if ({sample_ready, overrun, frame_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL spurious_done: got %b expected 100",
                     {sample_ready, overrun, frame_valid});
        end
        for (int k = 0; k < 16; k++) push(24'((500 + k) * 64));
        vectors++;
        if ({sample_ready, frame_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL spurious_swap: got %b expected 11",
                     {sample_ready, frame_valid});
        end
        read_at(4'd8, d);
        vectors++;
        if (d !== {24'd501, 24'h0}) begin
            miscompares++;
            $display("FAIL spurious_rd8: got %h expected %h", d, {24'd501, 24'h0});
        end
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        vectors++;
        if ({sample_ready, frame_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL release_empty: got %b expected 10",
                     {sample_ready, frame_valid});
        end
    endtask

    initial begin
        test_reset();
        test_bitrev_frame();
        test_scaling();
        test_overrun_hold();
        test_back_to_back();
        test_reset_midfill();
        test_spurious_done();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
